// File: rtl/serializer_pkg.sv
// Shared constants and FSM state type for the 16:1 parallel-in/serial-out path.
package serializer_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int SEL_WIDTH  = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/MUX_16_1.sv
// 16:1 single-bit multiplexer with an output enable that forces 0 when low.
module MUX_16_1
   import serializer_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] Data_In,
   input  logic [SEL_WIDTH-1:0]  Select_In,
   input  logic                  Enable_In,
   output logic                  Data_Out
);

   // Pick the selected bit, resolved to 0 while disabled.
   always_comb begin
      Data_Out = 1'b0;
      if (Enable_In) begin
         Data_Out = Data_In[Select_In];
      end else begin
         Data_Out = 1'b0;
      end
   end

endmodule

// File: rtl/piso_serializer_16.sv
// Parallel-in/serial-out front end: registers a 16-bit word on a valid/ready
// handshake and sweeps the MUX_16_1 select through all 16 bit slots.
module piso_serializer_16
   import serializer_pkg::*;
#(
   parameter int LSB_FIRST   = 1,
   parameter int HOLD_CYCLES = 1
)(
   input  logic                  Clk_In,
   input  logic                  Reset_n_In,
   input  logic                  Enable_In,
   input  logic [WORD_WIDTH-1:0] Data_In,
   input  logic                  Data_Valid_In,
   output logic                  Data_Ready_Out,
   output logic                  Serial_Data_Out,
   output logic                  Serial_Valid_Out,
   output logic [SEL_WIDTH-1:0]  Select_Out,
   output logic                  Frame_Start_Out,
   output logic                  Done_Out
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SEL_WIDTH-1:0] SEL_START = (LSB_FIRST != 0) ? SEL_WIDTH'(0)
                                                                 : SEL_WIDTH'(WORD_WIDTH - 1);
   localparam logic [SEL_WIDTH-1:0] BIT_LAST  = SEL_WIDTH'(WORD_WIDTH - 1);

   ser_state_t              state_q, state_d;
   logic [WORD_WIDTH-1:0]   data_q, data_d;
   logic [SEL_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
   logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
   logic [SEL_WIDTH-1:0]    sel_q, sel_d;

   logic shifting_s;
   logic hold_wrap_s;
   logic last_cycle_s;
   logic ready_s;
   logic accept_s;
   logic mux_en_s;
   logic mux_bit_s;

   assign shifting_s   = (state_q == SHIFT);
   assign hold_wrap_s  = (hold_cnt_q == HOLD_LAST);
   assign last_cycle_s = shifting_s && hold_wrap_s && (bit_cnt_q == BIT_LAST);
   // Reset is folded in so ready reads 0 while the block is held in reset.
   assign ready_s      = Reset_n_In && Enable_In && (!shifting_s || last_cycle_s);
   assign accept_s     = Data_Valid_In && ready_s;
   assign mux_en_s     = shifting_s && Enable_In;

   MUX_16_1 u_mux (
      .Data_In   (data_q),
      .Select_In (sel_q),
      .Enable_In (mux_en_s),
      .Data_Out  (mux_bit_s)
   );

   assign Data_Ready_Out   = ready_s;
   assign Serial_Data_Out  = mux_bit_s;
   assign Serial_Valid_Out = mux_en_s;
   assign Select_Out       = sel_q;
   assign Frame_Start_Out  = mux_en_s && (bit_cnt_q == SEL_WIDTH'(0)) && (hold_cnt_q == HOLD_W'(0));
   assign Done_Out         = Enable_In && last_cycle_s;

   // Next-state: accept wins over frame end so back-to-back frames have no gap.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      bit_cnt_d  = bit_cnt_q;
      hold_cnt_d = hold_cnt_q;
      sel_d      = sel_q;
      if (!Enable_In) begin
         state_d = state_q;
      end else if (accept_s) begin
         state_d    = SHIFT;
         data_d     = Data_In;
         bit_cnt_d  = SEL_WIDTH'(0);
         hold_cnt_d = HOLD_W'(0);
         sel_d      = SEL_START;
      end else if (shifting_s) begin
         if (hold_wrap_s) begin
            hold_cnt_d = HOLD_W'(0);
            bit_cnt_d  = bit_cnt_q + SEL_WIDTH'(1);
            sel_d      = (LSB_FIRST != 0) ? (sel_q + SEL_WIDTH'(1)) : (sel_q - SEL_WIDTH'(1));
            if (last_cycle_s) begin
               state_d = IDLE;
            end else begin
               state_d = SHIFT;
            end
         end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
      end else begin
         state_d = IDLE;
      end
   end

   // State, word and counter registers.
   always_ff @(posedge Clk_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state_q    <= IDLE;
         data_q     <= {WORD_WIDTH{1'b0}};
         bit_cnt_q  <= SEL_WIDTH'(0);
         hold_cnt_q <= HOLD_W'(0);
         sel_q      <= SEL_START;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         bit_cnt_q  <= bit_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         sel_q      <= sel_d;
      end
   end

endmodule
